br_csr_slot_releaser: RTL

Write-side companion to the BrCsr issue-queue free-slot list. It accepts slot-release notifications from two completion ports and buffers them in a per-slot pending bitmap. It then drains them into the free list one per cycle through the list's `Wable`/`Din`/`CriqFull` interface. It also snoops the list's read side so it can track slot ownership, and it honours the list's `CriqClean` flush.

---
 rtl/br_csr_slot_releaser.sv | 114 +++++++++++
 1 files changed

// File: rtl/br_csr_slot_releaser.sv
// Slot-release buffer for the BrCsr free list: captures released slots in a pending
// bitmap and writes them back one per cycle. Optional ownership checking: BRCSR_RELEASE_CHECK_EN.
module br_csr_slot_releaser #(
    parameter int SLOTWIDE = 4,
    parameter int SLOTNUM  = 4,
    parameter int SLOTSTEP = 4
) (
    input  logic                       Clk,
    input  logic                       Rest,
    input  logic                       RelValid0,
    input  logic [SLOTWIDE-1:0]        RelSlot0,
    input  logic                       RelValid1,
    input  logic [SLOTWIDE-1:0]        RelSlot1,
    input  logic                       FlRable,
    input  logic [SLOTWIDE-1:0]        FlPreOut,
    input  logic                       FlFull,
    input  logic                       CriqClean,
    output logic                       FlWable,
    output logic [SLOTWIDE-1:0]        FlDin,
    output logic [$clog2(SLOTNUM):0]   PendCnt,
    output logic                       RelError
);

    localparam int CNTW = $clog2(SLOTNUM) + 1;

    // One-hot slot decode; an all-zero result means the index is illegal.
    function automatic logic [SLOTNUM-1:0] decode(input logic v, input logic [SLOTWIDE-1:0] s);
        logic [SLOTNUM-1:0] oh;
        oh = '0;
        for (int unsigned k = 0; k < SLOTNUM; k++) begin
            if (v && (k * SLOTSTEP < (1 << SLOTWIDE)) && (s == SLOTWIDE'(k * SLOTSTEP)))
                oh[k] = 1'b1;
        end
        return oh;
    endfunction

    logic [SLOTNUM-1:0]  pending_q, pending_d;
    logic [SLOTNUM-1:0]  rel0_oh, rel1_oh, rel_oh;
    logic [SLOTNUM-1:0]  sel_oh, drain_oh;
    logic [SLOTWIDE-1:0] sel_din;
    logic [CNTW-1:0]     cnt;
    logic                found;

    always_comb begin
        rel0_oh = decode(RelValid0, RelSlot0);
        rel1_oh = decode(RelValid1, RelSlot1);
        rel_oh  = rel0_oh | rel1_oh;
    end

    always_comb begin
        sel_oh  = '0;
        sel_din = '0;
        found   = 1'b0;
        cnt     = '0;
        for (int unsigned k = 0; k < SLOTNUM; k++) begin
            if (pending_q[k] && !found) begin
                found     = 1'b1;
                sel_oh[k] = 1'b1;
                sel_din   = SLOTWIDE'(k * SLOTSTEP);
            end
            cnt = cnt + {{(CNTW-1){1'b0}}, pending_q[k]};
        end
        FlWable  = (|pending_q) & ~FlFull & ~CriqClean;
        FlDin    = FlWable ? sel_din : '0;
        drain_oh = FlWable ? sel_oh : '0;
        PendCnt  = cnt;
    end

    always_comb begin
        pending_d = CriqClean ? '0 : ((pending_q & ~drain_oh) | rel_oh);
    end

`ifdef BRCSR_RELEASE_CHECK_EN
    logic [SLOTNUM-1:0] in_use_q, in_use_d;
    logic [SLOTNUM-1:0] alloc_oh;
    logic               rel_error_q, rel_error_d;
    logic               err_hit;

    always_comb begin
        alloc_oh = decode(FlRable, FlPreOut);
        in_use_d = CriqClean ? '0 : ((in_use_q | alloc_oh) & ~rel_oh);
        err_hit  = (RelValid0 && (rel0_oh == '0))
                 | (RelValid1 && (rel1_oh == '0))
                 | (|(rel_oh & ~in_use_q))
                 | (|(rel_oh & pending_q))
                 | (|(rel0_oh & rel1_oh))
                 | (|(alloc_oh & rel_oh));
        // A flushed cycle discards its releases, so it cannot raise an error either.
        rel_error_d = rel_error_q | (err_hit & ~CriqClean);
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            in_use_q    <= '0;
            rel_error_q <= 1'b0;
        end else begin
            in_use_q    <= in_use_d;
            rel_error_q <= rel_error_d;
        end
    end

    assign RelError = rel_error_q;
`else
    logic unused_snoop;
    assign unused_snoop = ^{FlRable, FlPreOut};
    assign RelError     = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rest) pending_q <= '0;
        else      pending_q <= pending_d;
    end

endmodule
